uart_rx_core: RTL and testbench

Serial UART receiver for the SoC's `uart_rx` pin, in the core clock domain (20 MHz from the board PLL). Synchronises the asynchronous line, finds the start bit, samples 8N1 frames at mid-bit, and presents each byte on a single-entry valid/ready output. Flags framing errors and overruns as one-cycle pulses. It is the receiving end of the link the SoC's transmitter drives on the other side of the cable.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx_core.sv | 153 +++++++++++++++
 tb/tb_uart_rx_core.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous pad inputs
// Both stages reset to RESET_VAL so an idle-high line never looks like an edge.
module sync_2ff #(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with single-entry valid/ready output
// Samples each bit at mid-bit; framing errors and overruns are one-cycle pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 20000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;

    logic cnt_zero;
    logic byte_done;
    logic stop_bad;
    logic load;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // The counter only decrements while nonzero, so it never wraps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        cnt_zero  = (cnt_q == '0);

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = FULL_LOAD;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = FULL_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be caught.
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s) begin
                    byte_done = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stop_bad = 1'b1;
                    state_d  = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A byte may load into the holding register in the same cycle the old one is taken.
    always_comb begin
        load    = byte_done && (!valid_q || rx_ready);
        data_d  = load ? shift_q : data_q;
        valid_d = load || (valid_q && !rx_ready);
        ferr_d  = stop_bad;
        ovr_d   = byte_done && valid_q && !rx_ready;
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    int cyc = 0;
    int rise_cnt = 0;
    int rise_cyc = 0;
    int valid_hi = 0;
    int acc_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] acc_data = 8'h00;
    logic valid_prev = 1'b0;

    uart_rx_core #(
        .CLK_HZ       (20000000),
        .BAUD         (115200),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rx_valid && !valid_prev) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        valid_prev = rx_valid;
        if (rx_valid) valid_hi = valid_hi + 1;
        if (rx_valid && rx_ready) begin
            acc_cnt  = acc_cnt + 1;
            acc_data = rx_data;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (overrun) ovr_cnt = ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rx = stop;
        wait_cyc(CPB);
    endtask

    int fall_cyc, lat;
    int b_rise, b_hi, b_acc, b_ferr, b_ovr;

    task automatic snap();
        b_rise = rise_cnt;
        b_hi   = valid_hi;
        b_acc  = acc_cnt;
        b_ferr = ferr_cnt;
        b_ovr  = ovr_cnt;
    endtask

    initial begin
        reset_n  = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;

        // reset and idle
        wait_cyc(3);
        chk("reset_rx_data",   32'(rx_data),   32'h0);
        chk("reset_rx_valid",  32'(rx_valid),  32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_overrun",   32'(overrun),   32'h0);
        reset_n = 1'b1;
        snap();
        wait_cyc(100);
        chk("idle_no_valid", 32'(rise_cnt - b_rise), 32'd0);
        chk("idle_no_ferr",  32'(ferr_cnt - b_ferr), 32'd0);
        chk("idle_no_ovr",   32'(ovr_cnt - b_ovr),   32'd0);

        // single byte, consumer always ready
        rx_ready = 1'b1;
        snap();
        fall_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        wait_cyc(4);
        lat = rise_cyc - fall_cyc;
        chk("single_latency_in_window", 32'(lat >= 154 && lat <= 156), 32'd1);
        chk("single_valid_one_cycle", 32'(valid_hi - b_hi), 32'd1);
        chk("single_accept_count",    32'(acc_cnt - b_acc), 32'd1);
        chk("single_data",            32'(acc_data),        32'hA5);
        chk("single_no_pulses",       32'((ferr_cnt - b_ferr) + (ovr_cnt - b_ovr)), 32'd0);

        // back-to-back frames into a stalled consumer
        rx_ready = 1'b0;
        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_cyc(4);
        chk("b2b_overrun_pulses", 32'(ovr_cnt - b_ovr), 32'd2);
        chk("b2b_data_held",      32'(rx_data),  32'h00);
        chk("b2b_valid_held",     32'(rx_valid), 32'h1);
        chk("b2b_no_ferr",        32'(ferr_cnt - b_ferr), 32'd0);
        rx_ready = 1'b1;
        wait_cyc(3);
        chk("b2b_accept_count", 32'(acc_cnt - b_acc), 32'd1);
        chk("b2b_accept_data",  32'(acc_data), 32'h00);
        chk("b2b_valid_drops",  32'(rx_valid), 32'h0);

        // framing error, break, then a clean byte
        snap();
        send_frame(8'h55, 1'b0);
        wait_cyc(40);
        rx = 1'b1;
        wait_cyc(20);
        chk("ferr_one_pulse", 32'(ferr_cnt - b_ferr), 32'd1);
        chk("ferr_no_valid",  32'(rise_cnt - b_rise), 32'd0);
        chk("ferr_no_ovr",    32'(ovr_cnt - b_ovr),   32'd0);
        snap();
        send_frame(8'h12, 1'b1);
        wait_cyc(4);
        chk("after_ferr_accept_count", 32'(acc_cnt - b_acc), 32'd1);
        chk("after_ferr_data",         32'(acc_data), 32'h12);

        // 5-cycle glitch on an idle line
        snap();
        rx = 1'b0;
        wait_cyc(5);
        chk("glitch_start_seen", 32'(dut.state_q), 32'(ST_START));
        rx = 1'b1;
        wait_cyc(7);
        chk("glitch_idle_by_12", 32'(dut.state_q), 32'(ST_IDLE));
        wait_cyc(30);
        chk("glitch_no_valid", 32'(rise_cnt - b_rise), 32'd0);
        chk("glitch_no_pulse", 32'((ferr_cnt - b_ferr) + (ovr_cnt - b_ovr)), 32'd0);

        // reset asserted during data bit 3 of 0x81
        rx = 1'b0;
        wait_cyc(CPB);
        rx = 1'b1; wait_cyc(CPB);
        rx = 1'b0; wait_cyc(CPB);
        rx = 1'b0; wait_cyc(CPB);
        rx = 1'b0; wait_cyc(CPB / 2);
        chk("pre_reset_data_held", 32'(rx_data), 32'h12);
        reset_n = 1'b0;
        #1;
        chk("midreset_rx_data",   32'(rx_data),   32'h0);
        chk("midreset_rx_valid",  32'(rx_valid),  32'h0);
        chk("midreset_frame_err", 32'(frame_err), 32'h0);
        chk("midreset_overrun",   32'(overrun),   32'h0);
        chk("midreset_state",     32'(dut.state_q), 32'(ST_IDLE));
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(CPB / 2 - 2);
        rx = 1'b0; wait_cyc(3 * CPB);
        rx = 1'b1; wait_cyc(CPB);
        rx = 1'b1; wait_cyc(CPB);
        wait_cyc(200);
        snap();
        send_frame(8'h7E, 1'b1);
        wait_cyc(4);
        chk("recover_accept_count", 32'(acc_cnt - b_acc), 32'd1);
        chk("recover_data",         32'(acc_data), 32'h7E);
        chk("recover_no_ferr",      32'(ferr_cnt - b_ferr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
